// File: rtl/vedic_pkg.sv
// Shared types and helpers for the column-serial vedic multiplier.
//   state_t    : scheduler FSM states
//   WIDTH_DEF  : default operand width
//   cw_of()    : carry register width for a given operand width
package vedic_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // The carry out of any column is at most WIDTH-1.
    function automatic int unsigned cw_of(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/vedic_col_add.sv
// Combinational column adder: counts the partial-product bits of one column,
// adds the incoming carry, and splits the result into a product bit and the
// carry for the next column.
//   pp        : partial-product bits of the column (unused lanes must be 0)
//   carry_in  : carry from the previous column
//   sum_bit   : product bit for this column
//   carry_out : carry into the next column (sum >> 1)
module vedic_col_add #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 3
) (
    input  logic [W-1:0]  pp,
    input  logic [CW-1:0] carry_in,
    output logic          sum_bit,
    output logic [CW-1:0] carry_out
);

    // Column sum is at most W + (W-1), which fits in CW+1 bits.
    localparam int unsigned SW = CW + 1;

    logic [SW-1:0] sum;

    always_comb begin
        sum = SW'(carry_in);
        for (int i = 0; i < int'(W); i++) begin
            sum = sum + SW'(pp[i]);
        end
        sum_bit   = sum[0];
        carry_out = sum[SW-1:1];
    end

endmodule

// File: rtl/vedic_col_sched.sv
// Column-serial scheduler for the vedic multiplier. Latches one operand pair,
// feeds one product column per cycle through a shared column adder, builds
// the product one bit per cycle, then holds it on a valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake; a, b sampled on acceptance
//   out_valid/out_ready : product handshake; p held while out_valid is high
//   busy                : computing or holding a result
module vedic_col_sched
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CW    = cw_of(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int unsigned IW  = $clog2(WIDTH);
    localparam int unsigned CLW = $clog2(2 * WIDTH);
    localparam logic [CLW-1:0] LAST_COL = CLW'(2 * WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CLW-1:0]   col;
    logic [CW-1:0]    carry;

    logic [WIDTH-1:0] pp;
    logic             sum_bit;
    logic [CW-1:0]    carry_nxt;

    // Partial products a_q[i] & b_q[col-i]; lanes with col-i out of range are 0,
    // so the final column contributes only the carry.
    always_comb begin
        int j;
        j  = 0;
        pp = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            j = int'(col) - i;
            if (j >= 0 && j < int'(WIDTH)) begin
                pp[i] = a_q[i] & b_q[IW'(j)];
            end
        end
    end

    vedic_col_add #(
        .W  (WIDTH),
        .CW (CW)
    ) u_col_add (
        .pp        (pp),
        .carry_in  (carry),
        .sum_bit   (sum_bit),
        .carry_out (carry_nxt)
    );

    // Scheduler FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            col       <= '0;
            carry     <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        col      <= '0;
                        carry    <= '0;
                        p        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    p[col] <= sum_bit;
                    carry  <= carry_nxt;
                    col    <= col + CLW'(1);
                    if (col == LAST_COL) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // The product never exceeds 2*WIDTH bits, so nothing may carry out of the top column.
    always_ff @(posedge clk) begin
        if (rst_n && state == COMPUTE && col == LAST_COL) begin
            assert (carry_nxt == '0)
                else $error("vedic_col_sched: nonzero carry out of final column");
        end
    end

endmodule

// File: tb/tb_vedic_col_sched.sv
// Directed bench for vedic_col_sched (WIDTH=4): latency, products,
// backpressure, ignored input during compute, async reset, full sweep.
module tb_vedic_col_sched;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic       busy;

    int errors;
    int checks;

    vedic_col_sched #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply. stall<0: random out_ready; stall>=0: out_ready low for
    // 'stall' cycles once out_valid is seen (stall==0 keeps out_ready high
    // throughout). scramble keeps in_valid high with changing a/b after acceptance.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] exp, input int stall, input bit scramble);
        int lat;
        int guard;
        bit r;
        guard = 0;
        while (!in_ready && guard < 30) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        out_ready = (stall == 0) ? 1'b1 : 1'b0;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        tick();
        check("accepted_in_ready_low", 32'(in_ready), 32'd0);
        check("accepted_busy", 32'(busy), 32'd1);
        if (!scramble) begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            if (stall < 0) out_ready = 1'($urandom_range(0, 1));
            check("in_ready_low_compute", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd8);
        check("product", 32'(p), 32'(exp));
        check("busy_done", 32'(busy), 32'd1);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                out_ready = 1'b0;
                if (scramble) begin
                    a = 4'($urandom);
                    b = 4'($urandom);
                end
                tick();
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_product", 32'(p), 32'(exp));
                check("hold_in_ready_low", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            tick();
        end else if (stall == 0) begin
            tick();
        end else begin
            guard = 0;
            r = 1'b0;
            while (!r && guard < 40) begin
                r = 1'($urandom_range(0, 1));
                out_ready = r;
                tick();
                guard++;
                if (!r) begin
                    check("rand_hold_product", 32'(p), 32'(exp));
                    check("rand_hold_valid", 32'(out_valid), 32'd1);
                end
            end
            check("rand_handshake_done", 32'(r), 32'd1);
        end
        check("released_out_valid", 32'(out_valid), 32'd0);
        check("released_in_ready", 32'(in_ready), 32'd1);
        check("released_busy", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        run_op(4'hF, 4'hF, 8'hE1, 0, 1'b0);
        run_op(4'd3, 4'd5, 8'h0F, 0, 1'b0);
        run_op(4'd0, 4'hB, 8'h00, 0, 1'b0);
        run_op(4'd9, 4'd7, 8'h3F, 5, 1'b0);
        run_op(4'd12, 4'd10, 8'h78, 3, 1'b1);

        // Reset while column 3 of 15*13 is being computed.
        in_valid = 1'b1;
        a        = 4'd15;
        b        = 4'd13;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(4'd2, 4'd2, 8'h04, 0, 1'b0);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(4'(x), 4'(y), 8'(x * y), -1, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
